// File: rtl/misr_bist_pkg.sv
// Shared types and sequencing constants for the MISR BIST sequencer.
package misr_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_SETTLE,
    ST_CAPTURE,
    ST_COMPARE,
    ST_SHIFT,
    ST_DONE
  } bist_state_e;

  // Cycles spent holding the LFSR/MISR pair in clear.
  localparam int unsigned BIST_CLR_CYCLES    = 1;
  // Cycles between the last enabled cycle and the signature capture.
  localparam int unsigned BIST_SETTLE_CYCLES = 1;

endpackage

// File: rtl/sig_shift_out.sv
// Parallel-in serial-out readout register, LSB first, with a qualifying valid.
module sig_shift_out #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_bit,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_sh;
  logic             r_valid;

  // Clear wins over load, load wins over shift; zeros fill from the top.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh    <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_sh    <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_sh    <= i_data;
      r_valid <= 1'b1;
    end else if (i_shift) begin
      r_sh    <= r_sh >> 1;
    end
  end

  assign o_bit   = r_sh[0];
  assign o_valid = r_valid;

endmodule

// File: rtl/misr_sig_checker.sv
// BIST sequencer: clears and runs the LFSR/MISR pair, captures and checks the
// final signature, then shifts it out serially.
module misr_sig_checker
  import misr_bist_pkg::*;
#(
  parameter int LFSR_LENGTH   = 4,
  parameter int PATTERN_COUNT = 15,
  parameter int CNT_W         = $clog2(PATTERN_COUNT + 1)
) (
  input  logic                   lfsr_clk,
  input  logic                   resetn,
  input  logic                   bist_start,
  input  logic                   bist_abort,
  input  logic [LFSR_LENGTH-1:0] golden_sig,
  input  logic [LFSR_LENGTH-1:0] misr_state_out,
  output logic                   bist_clr_n,
  output logic                   pat_en,
  output logic                   bist_busy,
  output logic                   bist_done,
  output logic                   bist_pass,
  output logic [LFSR_LENGTH-1:0] sig_q,
  output logic                   sig_out,
  output logic                   sig_valid
);

  localparam int BIT_W = (LFSR_LENGTH > 1) ? $clog2(LFSR_LENGTH) : 1;
  localparam int unsigned PH_MAX = (BIST_CLR_CYCLES > BIST_SETTLE_CYCLES) ?
                                   BIST_CLR_CYCLES : BIST_SETTLE_CYCLES;
  localparam int PH_W = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  bist_state_e            r_state;
  bist_state_e            w_next;
  logic [CNT_W-1:0]       r_pat_cnt;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic [PH_W-1:0]        r_ph_cnt;
  logic                   r_clr_n;
  logic                   r_pat_en;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pass;
  logic [LFSR_LENGTH-1:0] r_sig_q;

  logic w_clr_n_d;
  logic w_pat_en_d;
  logic w_busy_d;
  logic w_done_d;
  logic w_clr_last;
  logic w_settle_last;
  logic w_run_last;
  logic w_shift_last;
  logic w_piso_load;
  logic w_piso_shift;
  logic w_piso_clear;

  assign w_clr_last    = (r_ph_cnt == PH_W'(BIST_CLR_CYCLES - 1));
  assign w_settle_last = (r_ph_cnt == PH_W'(BIST_SETTLE_CYCLES - 1));
  assign w_run_last    = (r_pat_cnt <= CNT_W'(1));
  assign w_shift_last  = (r_bit_cnt == BIT_W'(LFSR_LENGTH - 1));

  // State register.
  always_ff @(posedge lfsr_clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; abort overrides every transition, including start.
  always_comb begin
    w_next = r_state;
    if (bist_abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (bist_start) w_next = ST_CLEAR;
        ST_CLEAR:   if (w_clr_last) w_next = ST_RUN;
        ST_RUN:     if (w_run_last) w_next = ST_SETTLE;
        ST_SETTLE:  if (w_settle_last) w_next = ST_CAPTURE;
        ST_CAPTURE: w_next = ST_COMPARE;
        ST_COMPARE: w_next = ST_SHIFT;
        ST_SHIFT:   if (w_shift_last) w_next = ST_DONE;
        ST_DONE:    if (bist_start) w_next = ST_CLEAR;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  // Output decode from the next state so the registered outputs line up with the state.
  always_comb begin
    w_clr_n_d    = (w_next != ST_CLEAR);
    w_pat_en_d   = (w_next == ST_RUN);
    w_busy_d     = (w_next != ST_IDLE) && (w_next != ST_DONE);
    w_done_d     = (w_next == ST_DONE);
    w_piso_load  = (r_state == ST_COMPARE) && (w_next == ST_SHIFT);
    w_piso_shift = (r_state == ST_SHIFT);
    w_piso_clear = (w_next != ST_SHIFT);
  end

  // Registered control/status outputs; pass is cleared on abort and on restart.
  always_ff @(posedge lfsr_clk or negedge resetn) begin
    if (!resetn) begin
      r_clr_n  <= 1'b1;
      r_pat_en <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      r_clr_n  <= w_clr_n_d;
      r_pat_en <= w_pat_en_d;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;
      if ((w_next == ST_IDLE) || (w_next == ST_CLEAR)) r_pass <= 1'b0;
      else if (r_state == ST_COMPARE)                  r_pass <= (r_sig_q == golden_sig);
    end
  end

  // Signature capture; an abort in CAPTURE leaves the previous value in place.
  always_ff @(posedge lfsr_clk or negedge resetn) begin
    if (!resetn)                                              r_sig_q <= '0;
    else if ((r_state == ST_CAPTURE) && (w_next == ST_COMPARE)) r_sig_q <= misr_state_out;
  end

  // Pattern, bit and phase counters; all saturate rather than wrap.
  always_ff @(posedge lfsr_clk or negedge resetn) begin
    if (!resetn) begin
      r_pat_cnt <= '0;
      r_bit_cnt <= '0;
      r_ph_cnt  <= '0;
    end else begin
      if (r_state == ST_CLEAR)                        r_pat_cnt <= CNT_W'(PATTERN_COUNT);
      else if ((r_state == ST_RUN) && (r_pat_cnt != '0)) r_pat_cnt <= r_pat_cnt - CNT_W'(1);

      if (r_state == ST_COMPARE)                      r_bit_cnt <= '0;
      else if ((r_state == ST_SHIFT) && !w_shift_last) r_bit_cnt <= r_bit_cnt + BIT_W'(1);

      if (w_next != r_state)   r_ph_cnt <= '0;
      else if (r_ph_cnt != '1) r_ph_cnt <= r_ph_cnt + PH_W'(1);
    end
  end

  // Serial readout: bit k of the signature appears while r_bit_cnt == k.
  sig_shift_out #(
    .WIDTH (LFSR_LENGTH)
  ) u_sig_shift_out (
    .i_clk   (lfsr_clk),
    .i_rst_n (resetn),
    .i_load  (w_piso_load),
    .i_shift (w_piso_shift),
    .i_clear (w_piso_clear),
    .i_data  (r_sig_q),
    .o_bit   (sig_out),
    .o_valid (sig_valid)
  );

  assign bist_clr_n = r_clr_n;
  assign pat_en     = r_pat_en;
  assign bist_busy  = r_busy;
  assign bist_done  = r_done;
  assign bist_pass  = r_pass;
  assign sig_q      = r_sig_q;

endmodule

// File: tb/tb_misr_sig_checker.sv
// Directed bench for misr_sig_checker with a behavioural LFSR/MISR pair.
module tb_misr_sig_checker;

  logic       lfsr_clk = 1'b0;
  logic       resetn;
  logic       bist_start;
  logic       bist_abort;
  logic [3:0] golden_sig;
  logic [3:0] misr_state_out;
  logic       bist_clr_n;
  logic       pat_en;
  logic       bist_busy;
  logic       bist_done;
  logic       bist_pass;
  logic [3:0] sig_q;
  logic       sig_out;
  logic       sig_valid;

  logic [3:0] env_lfsr;
  logic [3:0] env_misr;
  logic [3:0] force_val;
  logic       force_en;

  int n_checks = 0;
  int n_errors = 0;

  misr_sig_checker #(
    .LFSR_LENGTH   (4),
    .PATTERN_COUNT (15)
  ) dut (
    .lfsr_clk       (lfsr_clk),
    .resetn         (resetn),
    .bist_start     (bist_start),
    .bist_abort     (bist_abort),
    .golden_sig     (golden_sig),
    .misr_state_out (misr_state_out),
    .bist_clr_n     (bist_clr_n),
    .pat_en         (pat_en),
    .bist_busy      (bist_busy),
    .bist_done      (bist_done),
    .bist_pass      (bist_pass),
    .sig_q          (sig_q),
    .sig_out        (sig_out),
    .sig_valid      (sig_valid)
  );

  always #5 lfsr_clk = ~lfsr_clk;

  // LFSR (x^4+x^3+1) and MISR pair sitting opposite the checker.
  always @(posedge lfsr_clk or negedge resetn) begin
    if (!resetn || !bist_clr_n) begin
      env_lfsr <= 4'b1101;
      env_misr <= 4'b0101;
    end else if (pat_en) begin
      env_misr <= {env_misr[2:0], env_misr[3] ^ env_misr[2]} ^ env_lfsr;
      env_lfsr <= {env_lfsr[2:0], env_lfsr[3] ^ env_lfsr[2]};
    end
  end

  assign misr_state_out = force_en ? force_val : env_misr;

  function automatic logic [3:0] model_sig();
    logic [3:0] l;
    logic [3:0] m;
    l = 4'b1101;
    m = 4'b0101;
    for (int i = 0; i < 15; i++) begin
      m = {m[2:0], m[3] ^ m[2]} ^ l;
      l = {l[2:0], l[3] ^ l[2]};
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_clr_n"},     32'(bist_clr_n), 32'd1);
    chk({pfx, "_pat_en"},    32'(pat_en),     32'd0);
    chk({pfx, "_busy"},      32'(bist_busy),  32'd0);
    chk({pfx, "_done"},      32'(bist_done),  32'd0);
    chk({pfx, "_pass"},      32'(bist_pass),  32'd0);
    chk({pfx, "_sig_q"},     32'(sig_q),      32'd0);
    chk({pfx, "_sig_out"},   32'(sig_out),    32'd0);
    chk({pfx, "_sig_valid"}, 32'(sig_valid),  32'd0);
  endtask

  // Called #1 after a rising edge with the block in IDLE or DONE.
  task automatic run_bist(input logic [3:0] gold, output int lat, output int n_pat,
                          output int n_clr, output int n_val, output logic [3:0] ser,
                          output logic first_done);
    logic [31:0] ser_word;
    golden_sig = gold;
    lat        = 0;
    n_pat      = 0;
    n_clr      = 0;
    n_val      = 0;
    ser_word   = '0;
    first_done = 1'b0;
    bist_start = 1'b1;
    do begin
      @(posedge lfsr_clk);
      #1;
      bist_start = 1'b0;
      lat++;
      if (lat == 1) first_done = bist_done;
      if (pat_en) n_pat++;
      if (!bist_clr_n) n_clr++;
      if (sig_valid) begin
        if (n_val < 32) ser_word = ser_word | (32'(sig_out) << n_val);
        n_val++;
      end
    end while (!bist_done && lat < 200);
    ser = ser_word[3:0];
  endtask

  logic [3:0] exp_sig;
  int         lat;
  int         n_pat;
  int         n_clr;
  int         n_val;
  logic [3:0] ser;
  logic       fd;
  int         k;

  initial begin
    exp_sig    = model_sig();
    resetn     = 1'b1;
    bist_start = 1'b0;
    bist_abort = 1'b0;
    golden_sig = '0;
    force_en   = 1'b0;
    force_val  = '0;
    #1 resetn  = 1'b0;
    repeat (3) @(posedge lfsr_clk);
    #1;
    chk_reset_vals("reset");
    resetn = 1'b1;
    @(posedge lfsr_clk);
    #1;

    // Pass case.
    run_bist(exp_sig, lat, n_pat, n_clr, n_val, ser, fd);
    chk("pass_latency",    32'(lat),       32'd24);
    chk("pass_pat_cycles", 32'(n_pat),     32'd15);
    chk("pass_clr_cycles", 32'(n_clr),     32'd1);
    chk("pass_done",       32'(bist_done), 32'd1);
    chk("pass_pass",       32'(bist_pass), 32'd1);
    chk("pass_busy",       32'(bist_busy), 32'd0);
    chk("pass_sig_q",      32'(sig_q),     32'(exp_sig));
    chk("pass_val_cycles", 32'(n_val),     32'd4);
    chk("pass_serial",     32'(ser),       32'(exp_sig));

    // Fail case, started from DONE (back-to-back).
    run_bist(exp_sig ^ 4'b0001, lat, n_pat, n_clr, n_val, ser, fd);
    chk("b2b_done_cleared", 32'(fd),        32'd0);
    chk("b2b_clr_cycles",   32'(n_clr),     32'd1);
    chk("fail_latency",     32'(lat),       32'd24);
    chk("fail_done",        32'(bist_done), 32'd1);
    chk("fail_pass",        32'(bist_pass), 32'd0);
    chk("b2b_sig_q",        32'(sig_q),     32'(exp_sig));
    repeat (2) @(posedge lfsr_clk);
    #1;
    chk("fail_done_held",   32'(bist_done), 32'd1);
    chk("fail_pass_held",   32'(bist_pass), 32'd0);

    // Serial readout of a forced signature.
    force_val = 4'b1010;
    force_en  = 1'b1;
    run_bist(4'b1010, lat, n_pat, n_clr, n_val, ser, fd);
    force_en  = 1'b0;
    chk("ser_sig_q",      32'(sig_q),     32'hA);
    chk("ser_val_cycles", 32'(n_val),     32'd4);
    chk("ser_bits",       32'(ser),       32'hA);
    chk("ser_pass",       32'(bist_pass), 32'd1);
    chk("ser_valid_low",  32'(sig_valid), 32'd0);

    // Abort on the 5th RUN cycle with an ignored start in the 3rd.
    bist_start = 1'b1;
    @(posedge lfsr_clk);
    #1;
    bist_start = 1'b0;
    chk("abort_in_clear", 32'(bist_clr_n), 32'd0);
    repeat (2) begin
      @(posedge lfsr_clk);
      #1;
    end
    @(posedge lfsr_clk);
    #1;
    bist_start = 1'b1;
    @(posedge lfsr_clk);
    #1;
    bist_start = 1'b0;
    chk("ign_start_pat_en", 32'(pat_en),     32'd1);
    chk("ign_start_clr_n",  32'(bist_clr_n), 32'd1);
    chk("ign_start_busy",   32'(bist_busy),  32'd1);
    @(posedge lfsr_clk);
    #1;
    bist_abort = 1'b1;
    @(posedge lfsr_clk);
    #1;
    bist_abort = 1'b0;
    chk("abort_pat_en", 32'(pat_en),     32'd0);
    chk("abort_busy",   32'(bist_busy),  32'd0);
    chk("abort_done",   32'(bist_done),  32'd0);
    chk("abort_pass",   32'(bist_pass),  32'd0);
    chk("abort_clr_n",  32'(bist_clr_n), 32'd1);
    chk("abort_valid",  32'(sig_valid),  32'd0);
    chk("abort_sig_q",  32'(sig_q),      32'hA);

    // Abort wins over a simultaneous start.
    bist_start = 1'b1;
    bist_abort = 1'b1;
    @(posedge lfsr_clk);
    #1;
    bist_start = 1'b0;
    bist_abort = 1'b0;
    chk("prio_clr_n", 32'(bist_clr_n), 32'd1);
    chk("prio_busy",  32'(bist_busy),  32'd0);

    // A fresh run after the abort completes normally.
    run_bist(exp_sig, lat, n_pat, n_clr, n_val, ser, fd);
    chk("post_abort_latency", 32'(lat),       32'd24);
    chk("post_abort_pat",     32'(n_pat),     32'd15);
    chk("post_abort_pass",    32'(bist_pass), 32'd1);
    chk("post_abort_sig_q",   32'(sig_q),     32'(exp_sig));

    // Reset in the 2nd SHIFT cycle.
    bist_start = 1'b1;
    @(posedge lfsr_clk);
    #1;
    bist_start = 1'b0;
    k = 0;
    while (!sig_valid && k < 40) begin
      @(posedge lfsr_clk);
      #1;
      k++;
    end
    chk("rst_shift_reached", 32'(sig_valid), 32'd1);
    @(posedge lfsr_clk);
    #1;
    chk("rst_shift_2nd", 32'(sig_valid), 32'd1);
    resetn = 1'b0;
    #1;
    chk_reset_vals("rst_mid_shift");
    @(posedge lfsr_clk);
    #1;
    resetn = 1'b1;
    @(posedge lfsr_clk);
    #1;

    // Normal run after the mid-shift reset.
    run_bist(exp_sig, lat, n_pat, n_clr, n_val, ser, fd);
    chk("post_rst_latency", 32'(lat),       32'd24);
    chk("post_rst_pass",    32'(bist_pass), 32'd1);
    chk("post_rst_serial",  32'(ser),       32'(exp_sig));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/misr_sig_checker.md
Name: misr_sig_checker

Overview:
BIST sequencer and signature reader that sits opposite the LFSR/MISR compaction pair.
- Clears the pair, then enables pattern generation and compaction for a fixed number of cycles.
- Captures the final MISR signature and compares it with a golden value.
- Reports pass/fail, and serially shifts the captured signature out for off-chip readback.

Parameters:
- LFSR_LENGTH, 4: width of the MISR signature (matches the MISR instance).
- PATTERN_COUNT, 15: number of enabled cycles per BIST run. Must be >= 1. 15 is the full period of the 4-bit maximal LFSR.
- CNT_W, $clog2(PATTERN_COUNT+1): width of the pattern counter. Derived; do not override.

Ports:
- lfsr_clk  input  1  single clock for the block and for the LFSR/MISR pair
- resetn  input  1  asynchronous, active-low reset
- bist_start  input  1  1-cycle pulse; starts a run when idle or done
- bist_abort  input  1  synchronous abort; returns the block to IDLE
- golden_sig  input  LFSR_LENGTH  expected signature; sampled in COMPARE
- misr_state_out  input  LFSR_LENGTH  MISR state from the MISR instance
- bist_clr_n  output  1  registered active-low clear to the LFSR/MISR pair, ANDed with resetn at the instances
- pat_en  output  1  registered enable; drives lfsr_en and misr_en
- bist_busy  output  1  high in every state except IDLE and DONE
- bist_done  output  1  high in DONE
- bist_pass  output  1  comparison result; valid while bist_done=1
- sig_q  output  LFSR_LENGTH  captured signature, held until the next capture
- sig_out  output  1  serial signature bit, LSB first
- sig_valid  output  1  qualifies sig_out

Behaviour:
- Reset (async, resetn=0): state=IDLE. bist_clr_n=1, pat_en=0, bist_busy=0, bist_done=0, bist_pass=0, sig_q=0, sig_out=0, sig_valid=0, counters=0.
- All outputs are registered.
- States: IDLE, CLEAR, RUN, SETTLE, CAPTURE, COMPARE, SHIFT, DONE.
- IDLE: when bist_start=1, go to CLEAR.
- CLEAR: exactly 1 cycle with bist_clr_n=0, which reseeds the LFSR/MISR. Then go to RUN, loading pat_cnt=PATTERN_COUNT.
- RUN: pat_en=1 for exactly PATTERN_COUNT consecutive cycles; pat_cnt decrements each cycle. pat_en falls in the same cycle the state moves to SETTLE.
- SETTLE: 1 cycle with pat_en=0. This lets the MISR's final enabled update land.
- CAPTURE: sig_q <= misr_state_out.
- COMPARE: bist_pass <= (sig_q == golden_sig). Go to SHIFT with bit_cnt=0.
- SHIFT: LFSR_LENGTH cycles; sig_out=sig_q[bit_cnt], sig_valid=1, bit_cnt increments. After the last bit, sig_valid drops and the state moves to DONE.
- DONE: bist_done=1 and bist_pass is held.
  - bist_start=1 in DONE clears bist_done and bist_pass and goes to CLEAR (back-to-back runs).
- Latency from a bist_start sample to bist_done=1 is 1+PATTERN_COUNT+1+1+1+LFSR_LENGTH+1 cycles. Default: 24.
- bist_start is ignored in every state other than IDLE and DONE.
- bist_abort:
  - From any state, go to IDLE next cycle.
  - pat_en=0, sig_valid=0, bist_clr_n=1, bist_done=0, bist_pass=0. sig_q keeps its value.
  - Abort has priority over start in the same cycle.
- Reset during RUN or SHIFT gives immediate reset values. No partial result is reported.
- Counter widths: pat_cnt is CNT_W bits and bit_cnt is $clog2(LFSR_LENGTH) bits (min 1). Neither wraps: both saturate at their terminal values in their respective states.

Decomposition:
- Package misr_bist_pkg:
  - state enum bist_state_e, covering the 8 states above
  - localparam BIST_CLR_CYCLES=1
  - localparam BIST_SETTLE_CYCLES=1
- One sub-module, sig_shift_out: parallel-load PISO of LFSR_LENGTH bits with load/shift/valid. It is reused by other BIST readouts.
- The FSM and counters stay in misr_sig_checker.

Test Plan:
- Pass case. Stimulus: release resetn, pulse bist_start, golden_sig = bench model MISR signature after 15 enabled cycles from seed 4'b0101 with LFSR seed 4'b1101. Required: pat_en high exactly 15 cycles, bist_clr_n low exactly 1 cycle, bist_done=1 at 24 cycles after start, bist_pass=1.
- Fail case. Stimulus: same run with golden_sig = model ^ 4'b0001. Required: bist_done=1, bist_pass=0, sig_q equal to the model value.
- Serial readout. Stimulus: force misr_state_out=4'b1010 during CAPTURE. Required: sig_valid high 4 cycles with sig_out = 0,1,0,1.
- Abort and ignored start. Stimulus: bist_abort on the 5th RUN cycle; bist_start pulse in the 3rd RUN cycle. Required: the start has no effect. Next cycle after abort: state IDLE, pat_en=0, bist_busy=0, bist_done=0. A new start then completes normally.
- Reset mid-SHIFT. Stimulus: resetn=0 in the 2nd SHIFT cycle. Required: all outputs go immediately to reset values, including sig_q=0 and sig_valid=0.
- Back-to-back runs. Stimulus: bist_start asserted in DONE. Required: bist_done clears, bist_clr_n pulses low, and the second run yields an identical sig_q.
